branch_predict_unit: RTL and testbench
======================================

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameters (name, default, meaning):
- BHT_DEPTH, 64, number of 2-bit predictor entries; power of two, >=2.
- PC_WIDTH, 32, PC width in bits.
REQ-002 Ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- if_pc  in  PC_WIDTH  fetch-stage PC for lookup.
- pred_taken  out  1  prediction for if_pc.
- ex_valid  in  1  EX-stage instruction valid.
- ex_pc  in  PC_WIDTH  EX-stage PC.
- Inst  in  32  EX-stage instruction word.
- BrEq  in  1  rs1==rs2 from the comparator.
- BrLT  in  1  rs1<rs2 from the comparator, signedness already applied.
- ex_pred_taken  in  1  prediction carried with the EX instruction.
- jump  out  1  resolved redirect.
- mispredict  out  1  conditional-branch prediction wrong.
- is_branch  out  1  EX instruction is a conditional branch.
REQ-003 One clock, clk; reset rst_n is synchronous and active-low.

Function
REQ-004 Index IDX = log2(BHT_DEPTH) bits, taken from pc[IDX+1:2]; pc[1:0] ignored.
REQ-005 Table holds BHT_DEPTH 2-bit saturating counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-006 pred_taken = MSB of the counter at the if_pc index; combinational read of registered state, zero-cycle latency.
REQ-007 Decode, combinational:
- opcode 1100011 -> is_branch=1.
- funct3 000 BEQ: jump=BrEq. 001 BNE: !BrEq. 100 BLT and 110 BLTU: BrLT. 101 BGE and 111 BGEU: !BrLT.
- funct3 010/011 on a branch opcode: is_branch=0, jump=0.
REQ-008 opcode 1101111 (JAL) or 1100111 (JALR) -> jump=1, is_branch=0.
REQ-009 Any other opcode -> jump=0, is_branch=0.
REQ-010 ex_valid=0 forces jump=0, is_branch=0, mispredict=0.
REQ-011 mispredict = ex_valid & is_branch & (jump != ex_pred_taken), combinational; JAL/JALR never assert it.
REQ-012 Update on a rising edge only when ex_valid & is_branch: counter at the ex_pc index increments if jump=1, else decrements; saturates at 11/00, no wrap.
REQ-013 Table is never written for jumps, invalid slots or non-branches.
REQ-014 Same-cycle lookup and update at the same index: pred_taken shows the pre-update value; the new value is visible the next cycle; no bypass.
REQ-015 Index aliasing is permitted: PCs differing only above bit IDX+1 share an entry.

Reset
REQ-016 While rst_n=0 at a rising edge, every counter becomes 01 (weak-NT); pred_taken reads 0 from the following cycle.
REQ-017 Reset overrides a same-cycle update; the update is lost.
REQ-018 jump, mispredict and is_branch are combinational and carry no reset value; they follow REQ-010 for whatever inputs are applied during reset.

Configuration
REQ-019 Macro BRANCH_PERF_EN:
- Defined: adds outputs br_count[31:0] and mis_count[31:0], reset to 0. br_count increments on each update of REQ-012; mis_count increments when mispredict=1 at a rising edge. Both wrap 0xFFFFFFFF->0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Verification
REQ-020 After reset, any if_pc -> pred_taken=0; Inst=0x0082_9C63 (BNE), BrEq=0, ex_pred_taken=0 -> jump=1, mispredict=1.
REQ-021 Inst=0x0073_4863 (BLT) at ex_pc=0x10, BrLT=1, for 3 edges -> counter at index 4 goes 01->10->11->11; pred_taken for if_pc=0x10 reads 1 after the first edge.
REQ-022 Inst=0x000A_8063 (BEQ), BrEq=1 -> jump=1. Inst=0xFF5F_F0EF (JAL) or 0xF9C3_82E7 (JALR), BrEq=0, BrLT=0 -> jump=1, mispredict=0, table unchanged.
REQ-023 Same-cycle lookup and update at if_pc=ex_pc=0x20 with counter 01 and jump=1 -> pred_taken=0 in that cycle, 1 in the next.
REQ-024 Drive ex_valid=0 with a BNE -> jump=0, no update. Assert rst_n=0 mid-sequence -> all entries 01.
REQ-025 With BRANCH_PERF_EN defined: 5 branches, 2 mispredicted -> br_count=5, mis_count=2.

Source files
------------

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - 2-bit saturating-counter BHT with EX-stage branch resolution (optional perf counters: BRANCH_PERF_EN)
module branch_predict_unit #(
  parameter int BHT_DEPTH = 64,
  parameter int PC_WIDTH  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PC_WIDTH-1:0] if_pc,
  output logic                pred_taken,
  input  logic                ex_valid,
  input  logic [PC_WIDTH-1:0] ex_pc,
  input  logic [31:0]         Inst,
  input  logic                BrEq,
  input  logic                BrLT,
  input  logic                ex_pred_taken,
  output logic                jump,
  output logic                mispredict,
  output logic                is_branch
`ifdef BRANCH_PERF_EN
  ,
  output logic [31:0]         br_count,
  output logic [31:0]         mis_count
`endif
);

  localparam int IDX = $clog2(BHT_DEPTH);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [1:0]     bht [BHT_DEPTH];
  logic [IDX-1:0] if_idx;
  logic [IDX-1:0] ex_idx;
  logic [6:0]     opcode;
  logic [2:0]     funct3;
  logic           dec_jump;
  logic           dec_branch;
  logic           unused_ok;

  // PC bits outside the index field and most instruction bits are deliberately ignored
  assign unused_ok = ^{if_pc, ex_pc, Inst};

  assign if_idx = if_pc[IDX+1:2];
  assign ex_idx = ex_pc[IDX+1:2];
  assign opcode = Inst[6:0];
  assign funct3 = Inst[14:12];

  // Prediction is the MSB of the registered counter; no bypass of a same-cycle update
  assign pred_taken = bht[if_idx][1];

  // Decode the EX instruction into branch/jump intent and branch outcome
  always_comb begin
    dec_jump   = 1'b0;
    dec_branch = 1'b0;
    case (opcode)
      OP_BRANCH: begin
        case (funct3)
          3'b000: begin dec_branch = 1'b1; dec_jump = BrEq;  end
          3'b001: begin dec_branch = 1'b1; dec_jump = !BrEq; end
          3'b100,
          3'b110: begin dec_branch = 1'b1; dec_jump = BrLT;  end
          3'b101,
          3'b111: begin dec_branch = 1'b1; dec_jump = !BrLT; end
          default: begin dec_branch = 1'b0; dec_jump = 1'b0; end
        endcase
      end
      OP_JAL, OP_JALR: dec_jump = 1'b1;
      default: begin
        dec_jump   = 1'b0;
        dec_branch = 1'b0;
      end
    endcase
  end

  assign jump       = ex_valid & dec_jump;
  assign is_branch  = ex_valid & dec_branch;
  assign mispredict = is_branch & (jump != ex_pred_taken);

  // Counter table: reset to weak-NT, otherwise train on resolved conditional branches
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (is_branch) begin
      if (jump) begin
        if (bht[ex_idx] != 2'b11) bht[ex_idx] <= bht[ex_idx] + 2'd1;
      end else begin
        if (bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'd1;
      end
    end
  end

`ifdef BRANCH_PERF_EN
  // Event counters for trained branches and mispredictions, wrapping naturally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_count  <= 32'd0;
      mis_count <= 32'd0;
    end else begin
      if (is_branch)  br_count  <= br_count + 32'd1;
      if (mispredict) mis_count <= mis_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - directed table-driven bench for branch_predict_unit
module tb_branch_predict_unit;

  localparam logic [31:0] I_BNE  = 32'h0082_9C63;
  localparam logic [31:0] I_BLT  = 32'h0073_4863;
  localparam logic [31:0] I_BEQ  = 32'h000A_8063;
  localparam logic [31:0] I_JAL  = 32'hFF5F_F0EF;
  localparam logic [31:0] I_JALR = 32'hF9C3_82E7;
  localparam logic [31:0] I_BGE  = 32'h0000_5063;
  localparam logic [31:0] I_BLTU = 32'h0000_6063;
  localparam logic [31:0] I_BGEU = 32'h0000_7063;
  localparam logic [31:0] I_F010 = 32'h0000_2063;
  localparam logic [31:0] I_F011 = 32'h0000_3063;
  localparam logic [31:0] I_ADD  = 32'h0000_0033;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] Inst;
  logic        BrEq;
  logic        BrLT;
  logic        ex_pred_taken;
  logic        jump;
  logic        mispredict;
  logic        is_branch;
`ifdef BRANCH_PERF_EN
  logic [31:0] br_count;
  logic [31:0] mis_count;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        v;
    logic [31:0] inst;
    logic        eq;
    logic        lt;
    logic        pt;
    logic        exp_jump;
    logic        exp_mis;
    logic        exp_br;
  } vec_t;

  vec_t vecs [16];

  branch_predict_unit #(.BHT_DEPTH(64), .PC_WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_pc         (if_pc),
    .pred_taken    (pred_taken),
    .ex_valid      (ex_valid),
    .ex_pc         (ex_pc),
    .Inst          (Inst),
    .BrEq          (BrEq),
    .BrLT          (BrLT),
    .ex_pred_taken (ex_pred_taken),
    .jump          (jump),
    .mispredict    (mispredict),
    .is_branch     (is_branch)
`ifdef BRANCH_PERF_EN
    ,
    .br_count      (br_count),
    .mis_count     (mis_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                          input logic eq, input logic lt, input logic pt);
    ex_valid      = v;
    ex_pc         = pc;
    Inst          = inst;
    BrEq          = eq;
    BrLT          = lt;
    ex_pred_taken = pt;
  endtask

  task automatic check_all_weak_nt(input string tag);
    for (int i = 0; i < 64; i++) begin
      if_pc = i * 4;
      #1;
      chk($sformatf("%s_entry%0d", tag, i), {31'd0, pred_taken}, 32'd0);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, I_BNE,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{1'b1, I_BNE,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, I_BEQ,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, I_BEQ,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, I_BLT,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, I_BGE,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, I_BGE,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, I_BLTU, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, I_BGEU, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, I_F010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, I_F011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, I_JAL,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, I_JALR, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b1, I_ADD,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, I_BNE,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, I_JAL,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    if_pc = 32'h0;
    drive_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();

    // Decode vectors applied while reset is held: outputs stay combinational, table untouched
    for (int i = 0; i < 16; i++) begin
      drive_ex(vecs[i].v, 32'h40, vecs[i].inst, vecs[i].eq, vecs[i].lt, vecs[i].pt);
      #2;
      chk($sformatf("vec%0d_jump", i),       {31'd0, jump},       {31'd0, vecs[i].exp_jump});
      chk($sformatf("vec%0d_mispredict", i), {31'd0, mispredict}, {31'd0, vecs[i].exp_mis});
      chk($sformatf("vec%0d_is_branch", i),  {31'd0, is_branch},  {31'd0, vecs[i].exp_br});
    end
    tick();
    drive_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    check_all_weak_nt("reset");
    if_pc = 32'h1234_5678;
    #1;
    chk("reset_arbitrary_pc", {31'd0, pred_taken}, 32'd0);

    // BLT taken three times at 0x10: 01->10->11->11
    if_pc = 32'h10;
    drive_ex(1'b1, 32'h10, I_BLT, 1'b0, 1'b1, 1'b0);
    #1;
    chk("blt_pre_edge", {31'd0, pred_taken}, 32'd0);
    tick(); chk("blt_edge1", {31'd0, pred_taken}, 32'd1);
    tick(); chk("blt_edge2", {31'd0, pred_taken}, 32'd1);
    tick(); chk("blt_edge3_sat", {31'd0, pred_taken}, 32'd1);
    // Not taken: 11->10->01->00->00, then taken 00->01->10
    BrLT = 1'b0;
    tick(); chk("dec_to_10", {31'd0, pred_taken}, 32'd1);
    tick(); chk("dec_to_01", {31'd0, pred_taken}, 32'd0);
    tick(); chk("dec_to_00", {31'd0, pred_taken}, 32'd0);
    tick(); chk("dec_sat_00", {31'd0, pred_taken}, 32'd0);
    BrLT = 1'b1;
    tick(); chk("inc_to_01", {31'd0, pred_taken}, 32'd0);
    tick(); chk("inc_to_10", {31'd0, pred_taken}, 32'd1);
    // Alias: ex_pc 0x113 shares index 4 with if_pc 0x10; not taken 10->01
    drive_ex(1'b1, 32'h113, I_BLT, 1'b0, 1'b0, 1'b1);
    tick(); chk("alias_update", {31'd0, pred_taken}, 32'd0);

    // JAL/JALR at 0x20 never train the table
    if_pc = 32'h20;
    drive_ex(1'b1, 32'h20, I_JAL, 1'b0, 1'b0, 1'b0);
    #1;
    chk("jal_jump", {31'd0, jump}, 32'd1);
    chk("jal_mispredict", {31'd0, mispredict}, 32'd0);
    tick();
    Inst = I_JALR;
    #1;
    chk("jalr_jump", {31'd0, jump}, 32'd1);
    tick();
    tick();
    chk("jump_no_train", {31'd0, pred_taken}, 32'd0);

    // Same-cycle lookup and update at 0x20: no bypass
    drive_ex(1'b1, 32'h20, I_BEQ, 1'b1, 1'b0, 1'b0);
    #1;
    chk("same_cycle_pre", {31'd0, pred_taken}, 32'd0);
    tick();
    drive_ex(1'b0, 32'h20, I_BEQ, 1'b0, 1'b0, 1'b0);
    #1;
    chk("same_cycle_next", {31'd0, pred_taken}, 32'd1);

    // Invalid slots never train: not-taken BEQ at 0x20 and BNE at 0x30
    tick();
    tick();
    chk("invalid_no_dec", {31'd0, pred_taken}, 32'd1);
    if_pc = 32'h30;
    drive_ex(1'b0, 32'h30, I_BNE, 1'b0, 1'b0, 1'b0);
    #1;
    chk("invalid_bne_jump", {31'd0, jump}, 32'd0);
    tick();
    tick();
    chk("invalid_no_inc", {31'd0, pred_taken}, 32'd0);

    // Reset with a same-cycle taken update at 0x40: update lost, all entries weak-NT
    rst_n = 1'b0;
    drive_ex(1'b1, 32'h40, I_BLT, 1'b0, 1'b1, 1'b0);
    tick();
    rst_n = 1'b1;
    drive_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_all_weak_nt("midreset");

`ifdef BRANCH_PERF_EN
    chk("br_count_reset", br_count, 32'd0);
    chk("mis_count_reset", mis_count, 32'd0);
    drive_ex(1'b1, 32'h80, I_BEQ, 1'b1, 1'b0, 1'b0); tick();
    drive_ex(1'b1, 32'h80, I_BEQ, 1'b0, 1'b0, 1'b0); tick();
    drive_ex(1'b1, 32'h80, I_BNE, 1'b1, 1'b0, 1'b0); tick();
    drive_ex(1'b1, 32'h80, I_JAL, 1'b0, 1'b0, 1'b0); tick();
    drive_ex(1'b1, 32'h80, I_BLT, 1'b0, 1'b1, 1'b1); tick();
    drive_ex(1'b1, 32'h80, I_BGE, 1'b0, 1'b1, 1'b1); tick();
    drive_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("br_count_5", br_count, 32'd5);
    chk("mis_count_2", mis_count, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
